// File: rtl/md_issue_if.sv
// HI/LO issue-control bundle between the pipeline/MD-unit side (master) and md_issue_ctrl (slave).
interface md_issue_if;
   logic       e_valid;
   logic [2:0] e_op;
   logic       d_is_md;
   logic       md_busy;
   logic       md_start;
   logic [2:0] md_op;
   logic       stall;
   logic [1:0] md_state;
   logic       md_timeout;

   modport master (
      output e_valid, e_op, d_is_md, md_busy,
      input  md_start, md_op, stall, md_state, md_timeout
   );

   modport slave (
      input  e_valid, e_op, d_is_md, md_busy,
      output md_start, md_op, stall, md_state, md_timeout
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: starts the HI/LO unit, tracks its busy window and stalls HI/LO users.
// Optional watchdog compiled in with `define MD_TIMEOUT_EN.
module md_issue_ctrl (
   input  logic        clk,
   input  logic        reset,
   md_issue_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       in_idle;
   logic       start_class;
   logic       fwd_class;
   logic       issue;
   logic [2:0] md_op_c;

   // Encoding 11 is unreachable and behaves exactly like IDLE.
   assign in_idle     = (state_q != ISSUE) && (state_q != WAIT);
   assign start_class = (bus.e_op >= 3'd1) && (bus.e_op <= 3'd4);
   assign fwd_class   = (bus.e_op != 3'd0) && (bus.e_op != 3'd7);

   // Gating with reset keeps md_start/md_op quiet while reset is held low.
   always_comb begin
      issue   = 1'b0;
      md_op_c = 3'b000;
      if (reset && bus.e_valid && in_idle) begin
         issue = start_class;
         if (fwd_class) begin
            md_op_c = bus.e_op;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d    = WAIT;
            wait_cnt_d = 4'd0;
         end
         WAIT: begin
            if (!bus.md_busy) begin
               state_d = IDLE;
            end
            if (wait_cnt_q != 4'd15) begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = issue ? ISSUE : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef MD_TIMEOUT_EN
   logic md_timeout_q, md_timeout_d;

   // Sticky: set on the edge where the WAIT counter becomes 12.
   always_comb begin
      md_timeout_d = md_timeout_q;
      if ((state_q == WAIT) && (wait_cnt_d == 4'd12)) begin
         md_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_timeout_q <= 1'b0;
      end else begin
         md_timeout_q <= md_timeout_d;
      end
   end

   assign bus.md_timeout = md_timeout_q;
`else
   assign bus.md_timeout = 1'b0;
`endif

   assign bus.md_start = issue;
   assign bus.md_op    = md_op_c;
   assign bus.stall    = bus.d_is_md & (issue | ~in_idle | bus.md_busy);
   assign bus.md_state = state_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed-vector bench for md_issue_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_md_issue_ctrl;

`ifdef MD_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;

   md_issue_if bus ();

   md_issue_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [2:0] op;
      logic       stall;
      logic [1:0] st;
      logic       tmo;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
   task automatic step(input logic rst, input logic ev, input logic [2:0] op,
                       input logic dmd, input logic busy,
                       input logic x_start, input logic [2:0] x_op, input logic x_stall,
                       input logic [1:0] x_st, input logic x_tmo, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      reset       = rst;
      bus.e_valid = ev;
      bus.e_op    = op;
      bus.d_is_md = dmd;
      bus.md_busy = busy;
      e.start = x_start;
      e.op    = x_op;
      e.stall = x_stall;
      e.st    = x_st;
      e.tmo   = x_tmo;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   // Monitor: compares on the falling edge, away from the active edge.
   initial begin
      exp_t       e;
      logic [7:0] got, want;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            got  = {bus.md_start, bus.md_op, bus.stall, bus.md_state, bus.md_timeout};
            want = {e.start, e.op, e.stall, e.st, e.tmo};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL %s: got start=%0b op=%03b stall=%0b state=%02b tmo=%0b, want start=%0b op=%03b stall=%0b state=%02b tmo=%0b",
                        e.name, bus.md_start, bus.md_op, bus.stall, bus.md_state, bus.md_timeout,
                        e.start, e.op, e.stall, e.st, e.tmo);
            end else begin
               $display("ok   %s: start=%0b op=%03b stall=%0b state=%02b tmo=%0b",
                        e.name, bus.md_start, bus.md_op, bus.stall, bus.md_state, bus.md_timeout);
            end
         end
      end
   end

   initial begin
      bus.e_valid = 1'b0;
      bus.e_op    = 3'b000;
      bus.d_is_md = 1'b0;
      bus.md_busy = 1'b0;

      // Held in reset: outputs quiet, stall only from d_is_md & md_busy
      step(0, 1, 3'b010, 1, 0,  0, 3'b000, 0, 2'b00, 0, "rst_outputs");
      step(0, 1, 3'b010, 1, 1,  0, 3'b000, 1, 2'b00, 0, "rst_stall_busy");

      // mult issued on the first edge after reset release
      step(1, 1, 3'b010, 0, 0,  1, 3'b010, 0, 2'b00, 0, "mult_issue");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b01, 0, "mult_issue_state");
      for (int i = 0; i < 5; i++)
         step(1, 0, 3'b000, 0, 1,  0, 3'b000, 0, 2'b10, 0, "mult_busy");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b10, 0, "mult_busy_fall");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "mult_idle");

      // div in E with mflo in D
      step(1, 1, 3'b100, 1, 0,  1, 3'b100, 1, 2'b00, 0, "div_issue_stall");
      step(1, 0, 3'b000, 1, 0,  0, 3'b000, 1, 2'b01, 0, "div_issue_state");
      for (int i = 0; i < 10; i++)
         step(1, 0, 3'b000, 1, 1,  0, 3'b000, 1, 2'b10, 0, "div_busy_stall");
      step(1, 0, 3'b000, 1, 0,  0, 3'b000, 1, 2'b10, 0, "div_busy_fall");
      step(1, 0, 3'b000, 1, 0,  0, 3'b000, 0, 2'b00, 0, "mflo_released");
      step(1, 1, 3'b111, 0, 0,  0, 3'b000, 0, 2'b00, 0, "mflo_in_e");

      // mthi / mtlo: forwarded op, no start, no FSM motion
      step(1, 1, 3'b101, 0, 0,  0, 3'b101, 0, 2'b00, 0, "mthi");
      step(1, 1, 3'b110, 0, 0,  0, 3'b110, 0, 2'b00, 0, "mtlo");
      step(1, 1, 3'b101, 1, 0,  0, 3'b101, 0, 2'b00, 0, "mthi_d_md_nostall");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "mthi_no_fsm");

      // divu, blocked reissue in WAIT, then asynchronous reset mid-WAIT
      step(1, 1, 3'b011, 0, 0,  1, 3'b011, 0, 2'b00, 0, "divu_issue");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b01, 0, "divu_issue_state");
      step(1, 0, 3'b000, 0, 1,  0, 3'b000, 0, 2'b10, 0, "divu_wait");
      step(1, 1, 3'b001, 1, 1,  0, 3'b000, 1, 2'b10, 0, "reissue_blocked");
      step(1, 0, 3'b000, 0, 1,  0, 3'b000, 0, 2'b10, 0, "reissue_no_change");
      step(0, 1, 3'b001, 0, 1,  0, 3'b000, 0, 2'b00, 0, "async_rst_mid_wait");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "post_rst_idle");

      // Unit busy while IDLE: stall only, no transition
      step(1, 0, 3'b000, 1, 1,  0, 3'b000, 1, 2'b00, 0, "idle_busy_stall");
      step(1, 0, 3'b000, 0, 1,  0, 3'b000, 0, 2'b00, 0, "idle_busy_nomd");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "idle_busy_notrans");

      // Watchdog: multu with busy held 20 cycles; counter hits 12 on the 13th WAIT edge
      step(1, 1, 3'b001, 0, 0,  1, 3'b001, 0, 2'b00, 0, "wdog_multu_issue");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b01, 0, "wdog_issue_state");
      for (int k = 3; k <= 22; k++)
         step(1, 0, 3'b000, 0, 1,  0, 3'b000, 0, 2'b10, (k >= 15) ? TMO_EN : 1'b0, "wdog_wait");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b10, TMO_EN, "wdog_busy_fall");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, TMO_EN, "wdog_sticky_idle");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, TMO_EN, "wdog_sticky_idle2");
      step(0, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "wdog_rst_clears");
      step(1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 2'b00, 0, "wdog_after_rst");

      // Give the monitor a bounded window to drain the scoreboard
      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have ports: e_valid  in  1  E-stage holds a real (non-bubble) instruction.
REQ-004 SHALL have ports: e_op  in  3  E-stage HI/LO op: 000 none, 001 multu, 010 mult, 011 divu, 100 div, 101 mthi, 110 mtlo, 111 mfhi/mflo.
REQ-005 SHALL have ports: d_is_md  in  1  D-stage instruction uses HI/LO (any nonzero op).
REQ-006 SHALL have ports: md_busy  in  1  Busy output of the multiply/divide unit.
REQ-007 SHALL have ports: md_start  out  1  start pulse to the unit.
REQ-008 SHALL have ports: md_op  out  3  op code to the unit.
REQ-009 SHALL have ports: stall  out  1  freeze F/D, bubble into E.
REQ-010 SHALL have ports: md_state  out  2  current FSM state, for debug.
REQ-011 SHALL have ports: md_timeout  out  1  sticky watchdog flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE=00, ISSUE=01, WAIT=10; 11 unreachable, decodes as IDLE.
REQ-013 SHALL define issue = e_valid & (state==IDLE) & e_op in {001,010,011,100}.
REQ-014 SHALL drive md_start = issue combinationally, one cycle wide.
REQ-015 SHALL drive md_op = e_op when e_valid & state==IDLE & e_op in 001..110, else 000.
REQ-016 SHALL never assert md_start for 101/110; mthi/mtlo pass md_op only, with md_start=0.
REQ-017 SHALL never forward 111 on md_op; mfhi/mflo read HI/LO directly and only cause stalls.
REQ-018 SHALL transition IDLE->ISSUE on issue, else stay in IDLE.
REQ-019 SHALL transition ISSUE->WAIT unconditionally; this covers the one-cycle gap before md_busy rises.
REQ-020 SHALL transition WAIT->IDLE in the cycle after md_busy is sampled 0, else stay in WAIT.
REQ-021 SHALL assert stall = d_is_md & (issue | state!=IDLE | md_busy), combinationally.
REQ-022 SHALL NOT stall non-HI/LO D-stage instructions, whatever the state.
REQ-023 SHALL ignore e_valid=1 with a start-class op while state!=IDLE: md_start=0, md_op=000, no state change.
REQ-024 SHALL treat md_busy=1 in IDLE (unit busy from before reset) as stall-only, with no transition.
REQ-025 SHALL keep a 4-bit wait counter: cleared on entering WAIT, incremented each WAIT cycle, saturating at 15.
REQ-026 SHALL hold md_op=000 and md_start=0 during reset.

Reset
REQ-027 SHALL, while reset=0, force asynchronously: state=IDLE, wait counter=0, md_timeout=0.
REQ-028 SHALL hold the reset outputs: md_start=0, md_op=000, md_state=00; stall=0 unless d_is_md & md_busy.
REQ-029 SHALL, on reset mid-operation (ISSUE/WAIT), abandon the operation; the unit is reset by the same system reset.
REQ-030 SHALL allow an issue on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL use macro MD_TIMEOUT_EN to compile the watchdog in or out.
REQ-032 SHALL, with MD_TIMEOUT_EN defined, set md_timeout=1 when the wait counter reaches 12 in WAIT; the flag stays set until reset.
REQ-033 SHALL, without MD_TIMEOUT_EN, tie md_timeout to 0 and remove the comparator; counter, FSM and stall stay identical.

Verification
REQ-034 SHALL cover: mult issue: e_valid=1, e_op=010 in IDLE -> md_start=1, md_op=010 for 1 cycle; state 01 then 10; busy 5 cycles; IDLE the cycle after busy falls.
REQ-035 SHALL cover: back-to-back: div in E, mflo in D on the same cycle -> stall=1 from issue cycle until the cycle busy=0 is sampled (>=11 cycles); mflo proceeds next cycle.
REQ-036 SHALL cover: mthi: e_op=101 in IDLE -> md_op=101, md_start=0, state stays 00, stall=0 for D-stage addu.
REQ-037 SHALL cover: reset mid-WAIT: reset=0 during divu busy -> state=00, md_start=0, md_timeout=0 immediately, without waiting for a clock edge.
REQ-038 SHALL cover: watchdog: hold md_busy=1 for 20 cycles after multu with MD_TIMEOUT_EN -> md_timeout=1 at wait count 12 and stays 1; without the macro, stays 0.
REQ-039 SHALL cover: illegal reissue: force e_op=001 while in WAIT -> md_start=0, md_op=000, state unchanged.
